bp_be_issue_queue: RTL and testbench

Circular instruction buffer between the front-end fetch interface and the backend checker. It pre-decodes each fetched RV64 instruction on enqueue and stores the register-dependency and hazard-class fields beside it. The head entry is presented as the issue status consumed by the hazard detector. An entry retires when the detector grants dispatch; a clear from the backend drains the queue on redirect.

---
 rtl/bp_be_pkg.sv | 28 ++
 rtl/bp_common_rv64_pkg.sv | 39 +++
 rtl/bp_be_instr_predecode.sv | 83 ++++++++
 rtl/bp_be_issue_queue.sv | 113 +++++++++++
 tb/tb_bp_be_issue_queue.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pkg.sv
// Backend types: the issue-status pre-decode record and the issue queue entry.
package bp_be_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;

    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rs3_addr;
        logic       irs1_v;
        logic       irs2_v;
        logic       frs1_v;
        logic       frs2_v;
        logic       frs3_v;
        logic       fence_v;
        logic       mem_v;
        logic       csr_v;
        logic       long_v;
    } bp_be_isd_status_s;

    typedef struct packed {
        logic [vaddr_width_gp-1:0] pc;
        logic [instr_width_gp-1:0] instr;
        bp_be_isd_status_s         isd_status;
    } bp_be_issue_queue_entry_s;

endpackage

// File: rtl/bp_common_rv64_pkg.sv
// RV64 opcode and function-field constants used by the backend pre-decoder.
// Opcodes are given as instr[6:2]; the low two bits are always 2'b11 for RV64.
package bp_common_rv64_pkg;

    localparam logic [4:0] rv64_load_op      = 5'b00000;
    localparam logic [4:0] rv64_load_fp_op   = 5'b00001;
    localparam logic [4:0] rv64_misc_mem_op  = 5'b00011;
    localparam logic [4:0] rv64_op_imm_op    = 5'b00100;
    localparam logic [4:0] rv64_op_imm_32_op = 5'b00110;
    localparam logic [4:0] rv64_store_op     = 5'b01000;
    localparam logic [4:0] rv64_store_fp_op  = 5'b01001;
    localparam logic [4:0] rv64_amo_op       = 5'b01011;
    localparam logic [4:0] rv64_op_op        = 5'b01100;
    localparam logic [4:0] rv64_op_32_op     = 5'b01110;
    localparam logic [4:0] rv64_fmadd_op     = 5'b10000;
    localparam logic [4:0] rv64_fmsub_op     = 5'b10001;
    localparam logic [4:0] rv64_fnmsub_op    = 5'b10010;
    localparam logic [4:0] rv64_fnmadd_op    = 5'b10011;
    localparam logic [4:0] rv64_op_fp_op     = 5'b10100;
    localparam logic [4:0] rv64_branch_op    = 5'b11000;
    localparam logic [4:0] rv64_jalr_op      = 5'b11001;
    localparam logic [4:0] rv64_system_op    = 5'b11100;

    // M-extension funct7 shared by mul/div/rem
    localparam logic [6:0] rv64_funct7_muldiv = 7'b0000001;

    // OP-FP funct5 values that matter for operand and latency classification
    localparam logic [4:0] rv64_fp_fadd   = 5'b00000;
    localparam logic [4:0] rv64_fp_fsub   = 5'b00001;
    localparam logic [4:0] rv64_fp_fmul   = 5'b00010;
    localparam logic [4:0] rv64_fp_fdiv   = 5'b00011;
    localparam logic [4:0] rv64_fp_fsgnj  = 5'b00100;
    localparam logic [4:0] rv64_fp_fminmax= 5'b00101;
    localparam logic [4:0] rv64_fp_fsqrt  = 5'b01011;
    localparam logic [4:0] rv64_fp_fcmp   = 5'b10100;
    localparam logic [4:0] rv64_fp_fcvt_i2f = 5'b11010;
    localparam logic [4:0] rv64_fp_fmv_x2f  = 5'b11110;

endpackage

// File: rtl/bp_be_instr_predecode.sv
// Combinational pre-decode of one RV64 instruction into register-dependency
// and hazard-class flags consumed by the hazard detector.
module bp_be_instr_predecode
    import bp_common_rv64_pkg::*;
    import bp_be_pkg::*;
(
    input  logic [31:0]       instr_i,
    output bp_be_isd_status_s isd_status_o
);

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] funct5;
    logic       unused_bits;

    assign opcode      = instr_i[6:2];
    assign funct3      = instr_i[14:12];
    assign funct7      = instr_i[31:25];
    assign funct5      = instr_i[31:27];
    assign unused_bits = ^{instr_i[11:7], instr_i[1:0]};

    // Classify the opcode; register addresses are extracted unconditionally
    always_comb begin
        isd_status_o          = '0;
        isd_status_o.rs1_addr = instr_i[19:15];
        isd_status_o.rs2_addr = instr_i[24:20];
        isd_status_o.rs3_addr = instr_i[31:27];
        case (opcode)
            rv64_op_op, rv64_op_32_op: begin
                isd_status_o.irs1_v = 1'b1;
                isd_status_o.irs2_v = 1'b1;
                isd_status_o.long_v = (funct7 == rv64_funct7_muldiv) && funct3[2];
            end
            rv64_op_imm_op, rv64_op_imm_32_op, rv64_jalr_op: begin
                isd_status_o.irs1_v = 1'b1;
            end
            rv64_load_op: begin
                isd_status_o.irs1_v = 1'b1;
                isd_status_o.mem_v  = 1'b1;
            end
            rv64_store_op, rv64_amo_op: begin
                isd_status_o.irs1_v = 1'b1;
                isd_status_o.irs2_v = 1'b1;
                isd_status_o.mem_v  = 1'b1;
            end
            rv64_branch_op: begin
                isd_status_o.irs1_v = 1'b1;
                isd_status_o.irs2_v = 1'b1;
            end
            rv64_load_fp_op: begin
                isd_status_o.irs1_v = 1'b1;
                isd_status_o.mem_v  = 1'b1;
            end
            rv64_store_fp_op: begin
                isd_status_o.irs1_v = 1'b1;
                isd_status_o.frs2_v = 1'b1;
                isd_status_o.mem_v  = 1'b1;
            end
            rv64_fmadd_op, rv64_fmsub_op, rv64_fnmsub_op, rv64_fnmadd_op: begin
                isd_status_o.frs1_v = 1'b1;
                isd_status_o.frs2_v = 1'b1;
                isd_status_o.frs3_v = 1'b1;
            end
            rv64_op_fp_op: begin
                isd_status_o.frs1_v = !(funct5 inside {rv64_fp_fcvt_i2f, rv64_fp_fmv_x2f});
                isd_status_o.frs2_v = funct5 inside {rv64_fp_fadd, rv64_fp_fsub, rv64_fp_fmul,
                                                     rv64_fp_fdiv, rv64_fp_fsgnj, rv64_fp_fminmax,
                                                     rv64_fp_fcmp};
                isd_status_o.long_v = funct5 inside {rv64_fp_fdiv, rv64_fp_fsqrt};
            end
            rv64_misc_mem_op: begin
                isd_status_o.fence_v = 1'b1;
            end
            rv64_system_op: begin
                isd_status_o.csr_v  = 1'b1;
                isd_status_o.irs1_v = (funct3 != 3'b000) && !funct3[2];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Circular issue buffer between fetch and the backend hazard checker.
// Instructions are pre-decoded on enqueue; the head entry is the issue status.
// Optional feature macro: BP_BE_ISSUE_QUEUE_BYPASS_EN (same-cycle empty bypass).
module bp_be_issue_queue
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p = vaddr_width_gp,
    parameter int instr_width_p = instr_width_gp,
    parameter int els_p         = 8
)(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     fe_v_i,
    input  logic [vaddr_width_p-1:0] fe_pc_i,
    input  logic [instr_width_p-1:0] fe_instr_i,
    output logic                     fe_ready_o,
    output logic                     issue_v_o,
    output logic [vaddr_width_p-1:0] issue_pc_o,
    output logic [instr_width_p-1:0] issue_instr_o,
    output bp_be_isd_status_s        isd_status_o,
    input  logic                     deq_i,
    input  logic                     clear_i,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_count = cnt_w'(els_p);

    bp_be_issue_queue_entry_s mem_r [els_p];
    bp_be_issue_queue_entry_s enq_entry;
    bp_be_issue_queue_entry_s head_entry;
    bp_be_isd_status_s        enq_status;

    logic [ptr_w-1:0] rptr_r, wptr_r;
    logic [cnt_w-1:0] count_r, count_n;
    logic             full_r, empty_r;
    logic             enq_v, deq_v, bypass_v;

    bp_be_instr_predecode predecode (
        .instr_i      (fe_instr_i[31:0]),
        .isd_status_o (enq_status)
    );

    assign enq_entry = '{pc: fe_pc_i, instr: fe_instr_i, isd_status: enq_status};

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    assign bypass_v = empty_r & fe_v_i & ~clear_i;
`else
    assign bypass_v = 1'b0;
`endif

    assign fe_ready_o = ~full_r;
    assign full_o     = full_r;
    assign empty_o    = empty_r;
    assign issue_v_o  = ~empty_r | bypass_v;
    assign enq_v      = fe_v_i & ~full_r & ~clear_i;
    assign deq_v      = deq_i & issue_v_o & ~clear_i;

    // Next occupancy: a simultaneous enqueue and dequeue leaves it unchanged
    always_comb begin
        count_n = count_r;
        case ({enq_v, deq_v})
            2'b10:   count_n = count_r + 1'b1;
            2'b01:   count_n = count_r - 1'b1;
            default: count_n = count_r;
        endcase
    end

    // Pointer, occupancy and status flags; reset and clear both empty the queue
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clear_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (enq_v) wptr_r <= wptr_r + 1'b1;
            if (deq_v) rptr_r <= rptr_r + 1'b1;
            count_r <= count_n;
            full_r  <= (count_n == full_count);
            empty_r <= (count_n == '0);
        end
    end

    // Entry storage; contents need no reset because occupancy gates them
    always_ff @(posedge clk_i) begin
        if (enq_v) mem_r[wptr_r] <= enq_entry;
    end

    // Head presentation, with the fetch packet forwarded when bypassing
    always_comb begin
        head_entry = mem_r[rptr_r];
        if (bypass_v) head_entry = enq_entry;
        issue_pc_o    = head_entry.pc;
        issue_instr_o = head_entry.instr;
        isd_status_o  = head_entry.isd_status;
        if (!issue_v_o) begin
            isd_status_o.irs1_v  = 1'b0;
            isd_status_o.irs2_v  = 1'b0;
            isd_status_o.frs1_v  = 1'b0;
            isd_status_o.frs2_v  = 1'b0;
            isd_status_o.frs3_v  = 1'b0;
            isd_status_o.fence_v = 1'b0;
            isd_status_o.mem_v   = 1'b0;
            isd_status_o.csr_v   = 1'b0;
            isd_status_o.long_v  = 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Self-checking bench for bp_be_issue_queue: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_bp_be_issue_queue;
    import bp_be_pkg::*;

    localparam int els = 8;

    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
    } pkt_t;

    logic              clk = 1'b0;
    logic              reset_n_i;
    logic              fe_v_i;
    logic [38:0]       fe_pc_i;
    logic [31:0]       fe_instr_i;
    logic              fe_ready_o;
    logic              issue_v_o;
    logic [38:0]       issue_pc_o;
    logic [31:0]       issue_instr_o;
    bp_be_isd_status_s isd_status_o;
    logic              deq_i;
    logic              clear_i;
    logic              empty_o;
    logic              full_o;

    pkt_t        model_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [38:0] next_pc  = 39'h80000000;

    always #5 clk = ~clk;

    bp_be_issue_queue #(.vaddr_width_p(39), .instr_width_p(32), .els_p(els)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .fe_v_i        (fe_v_i),
        .fe_pc_i       (fe_pc_i),
        .fe_instr_i    (fe_instr_i),
        .fe_ready_o    (fe_ready_o),
        .issue_v_o     (issue_v_o),
        .issue_pc_o    (issue_pc_o),
        .issue_instr_o (issue_instr_o),
        .isd_status_o  (isd_status_o),
        .deq_i         (deq_i),
        .clear_i       (clear_i),
        .empty_o       (empty_o),
        .full_o        (full_o)
    );

    // Reference pre-decode written from the full 7-bit opcode values
    function automatic bp_be_isd_status_s refDecode(input logic [31:0] ins);
        bp_be_isd_status_s s;
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] f5;
        bit fma, opfp, sys;
        op   = ins[6:0];
        f3   = ins[14:12];
        f5   = ins[31:27];
        fma  = (op == 7'h43) || (op == 7'h47) || (op == 7'h4b) || (op == 7'h4f);
        opfp = (op == 7'h53);
        sys  = (op == 7'h73);
        s = '0;
        s.rs1_addr = ins[19:15];
        s.rs2_addr = ins[24:20];
        s.rs3_addr = ins[31:27];
        s.irs1_v  = (op == 7'h33) || (op == 7'h13) || (op == 7'h3b) || (op == 7'h1b) ||
                    (op == 7'h03) || (op == 7'h23) || (op == 7'h63) || (op == 7'h67) ||
                    (op == 7'h2f) || (op == 7'h07) || (op == 7'h27) ||
                    (sys && f3 != 3'd0 && f3 < 3'd4);
        s.irs2_v  = (op == 7'h33) || (op == 7'h3b) || (op == 7'h23) || (op == 7'h63) || (op == 7'h2f);
        s.frs1_v  = fma || (opfp && f5 != 5'd26 && f5 != 5'd30);
        s.frs2_v  = fma || (op == 7'h27) ||
                    (opfp && (f5 <= 5'd5 || f5 == 5'd20));
        s.frs3_v  = fma;
        s.mem_v   = (op == 7'h03) || (op == 7'h23) || (op == 7'h07) || (op == 7'h27) || (op == 7'h2f);
        s.fence_v = (op == 7'h0f);
        s.csr_v   = sys;
        s.long_v  = (((op == 7'h33) || (op == 7'h3b)) && ins[31:25] == 7'd1 && f3 >= 3'd4) ||
                    (opfp && (f5 == 5'd3 || f5 == 5'd11));
        return s;
    endfunction

    function automatic logic [8:0] validBits(input bp_be_isd_status_s s);
        return {s.irs1_v, s.irs2_v, s.frs1_v, s.frs2_v, s.frs3_v,
                s.fence_v, s.mem_v, s.csr_v, s.long_v};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every registered output against the reference queue contents
    task automatic checkState(input string tag);
        int sz;
        sz = model_q.size();
        checkOutput({tag, ".issue_v"}, 64'(issue_v_o), 64'(sz > 0));
        checkOutput({tag, ".empty"},   64'(empty_o),   64'(sz == 0));
        checkOutput({tag, ".full"},    64'(full_o),    64'(sz == els));
        checkOutput({tag, ".ready"},   64'(fe_ready_o),64'(sz < els));
        if (sz > 0) begin
            checkOutput({tag, ".pc"},    64'(issue_pc_o),    64'(model_q[0].pc));
            checkOutput({tag, ".instr"}, 64'(issue_instr_o), 64'(model_q[0].instr));
            checkOutput({tag, ".isd"},   64'(isd_status_o),  64'(refDecode(model_q[0].instr)));
        end else begin
            checkOutput({tag, ".isd_v"}, 64'(validBits(isd_status_o)), 64'd0);
        end
    endtask

    // Advance the reference queue by one clock using its pre-edge contents
    task automatic modelStep(input logic v, input logic [38:0] pc, input logic [31:0] instr,
                             input logic deq, input logic clr);
        int   sz;
        bit   head_v, do_enq, do_deq;
        pkt_t tmp;
        sz     = model_q.size();
        head_v = (sz > 0);
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        if (sz == 0 && v && !clr) head_v = 1'b1;
`endif
        if (clr) begin
            model_q.delete();
        end else begin
            do_enq = v && (sz < els);
            do_deq = deq && head_v;
            if (do_deq && sz > 0) tmp = model_q.pop_front();
            if (do_enq && !(do_deq && sz == 0)) model_q.push_back('{pc, instr});
        end
    endtask

    // Drive one cycle of inputs, clock it, then return inputs to idle
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic deq, input logic clr);
        fe_v_i     = v;
        fe_pc_i    = next_pc;
        fe_instr_i = instr;
        deq_i      = deq;
        clear_i    = clr;
        modelStep(v, next_pc, instr, deq, clr);
        if (v) next_pc = next_pc + 39'd4;
        @(posedge clk);
        #1;
        fe_v_i  = 1'b0;
        deq_i   = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic doReset();
        reset_n_i = 1'b0;
        fe_v_i    = 1'b0;
        deq_i     = 1'b0;
        clear_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        model_q.delete();
    endtask

    // Enqueue one instruction into an empty queue, check its flags, then drain it
    task automatic directedDecode(input string tag, input logic [31:0] instr,
                                  input logic [8:0] exp_v, input logic [4:0] exp_rs3);
        applyStimulus(1'b1, instr, 1'b0, 1'b0);
        checkOutput({tag, ".valid_bits"}, 64'(validBits(isd_status_o)), 64'(exp_v));
        checkOutput({tag, ".rs3"},        64'(isd_status_o.rs3_addr),   64'(exp_rs3));
        checkState(tag);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] ops [17];
        logic [31:0] r;
        ops = '{7'h03, 7'h07, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h27, 7'h2f,
                7'h33, 7'h37, 7'h3b, 7'h43, 7'h53, 7'h63, 7'h67, 7'h73};
        r = $urandom;
        if ($urandom_range(0, 3) == 0 && (ops[0] == 7'h03)) r[31:25] = 7'd1;
        r[6:0] = ops[$urandom_range(0, 16)];
        return r;
    endfunction

    initial begin
        fe_pc_i    = '0;
        fe_instr_i = '0;
        doReset();
        checkState("reset");

        // ADD x3,x1,x2: same-cycle visibility depends on the bypass build
        fe_v_i     = 1'b1;
        fe_pc_i    = next_pc;
        fe_instr_i = 32'h002081B3;
        #1;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        checkOutput("bypass_same_cycle", 64'(issue_v_o), 64'd1);
`else
        checkOutput("no_bypass_same_cycle", 64'(issue_v_o), 64'd0);
`endif
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        checkOutput("add.pc", 64'(issue_pc_o), 64'h80000000);
        checkOutput("add.rs1", 64'(isd_status_o.rs1_addr), 64'd1);
        checkOutput("add.rs2", 64'(isd_status_o.rs2_addr), 64'd2);
        checkOutput("add.valid_bits", 64'(validBits(isd_status_o)), 64'b110000000);
        checkState("add");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("add_drain");

        // Fill to full, drop a ninth packet, then drain in order
        for (int i = 0; i < els; i++) applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        checkState("filled");
        applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        checkState("ninth_dropped");
        for (int i = 0; i < els; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            checkState("drain");
        end

        // Full with simultaneous dequeue and fetch: the fetch packet is dropped
        for (int i = 0; i < els; i++) applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        applyStimulus(1'b1, randInstr(), 1'b1, 1'b0);
        checkState("full_enq_deq");
        while (model_q.size() > 0) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Pointer wrap with occupancy held at three
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, randInstr(), 1'b1, 1'b0);
            checkState("wrap");
        end

        // Clear at occupancy five with a same-cycle fetch
        applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        applyStimulus(1'b1, randInstr(), 1'b0, 1'b1);
        checkState("clear");
        applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        checkState("after_clear");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Pre-decode classes with independently written expectations
        directedDecode("fmadd_d", 32'h223100C3, 9'b001110000, 5'd4);
        directedDecode("divw",    32'h027342BB, 9'b110000001, 5'd0);
        directedDecode("fence",   32'h0FF0000F, 9'b000001000, 5'd1);
        directedDecode("csrrw",   32'h300110F3, 9'b100000010, 5'd6);
        directedDecode("csrrwi",  32'h3002D0F3, 9'b000000010, 5'd6);

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
            checkState("random");
        end

        // Reset in the middle of traffic discards everything
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
        doReset();
        checkState("mid_reset");

        $display("[TB] directed and random sequences complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
